// File: rtl/l1_tag_update_ctrl_pkg.sv
// Shared sizing constants and FSM encoding for the L1 tag/valid array update controller.
// Every block that touches the tag array imports these so they agree on geometry.
package l1_tag_update_ctrl_pkg;

  localparam int L1_NUM_SETS        = 64;
  localparam int L1_SET_INDEX_WIDTH = 6;
  localparam int L1_TAG_WIDTH       = 20;
  localparam int L1_WAY_W           = 2;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_FLUSH = 2'd1,
    STATE_DONE  = 2'd2
  } l1_state_e;

endpackage

// File: rtl/l1_tag_update_ctrl_fill_fifo.sv
// Two-entry FIFO holding pending L2 fills as packed {way, tag, set} words.
// Push is dropped when full and pop is dropped when empty, so callers may gate loosely.
module l1_fill_fifo
  import l1_tag_update_ctrl_pkg::*;
#(
  parameter int W = L1_WAY_W + L1_TAG_WIDTH + L1_SET_INDEX_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l1_tag_update_ctrl.sv
// Sequences fills, single-way invalidates and whole-cache flushes into one L1 tag array
// through a registered update/invalidate port; lookups are stalled while a flush walks the sets.
module l1_tag_update_ctrl
  import l1_tag_update_ctrl_pkg::*;
#(
  parameter int NUM_SETS = L1_NUM_SETS,
  parameter int SET_W    = L1_SET_INDEX_WIDTH,
  parameter int TAG_W    = L1_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_valid_i,
  input  logic [1:0]       fill_way_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [SET_W-1:0] fill_set_i,
  output logic             fill_ready_o,
  input  logic             inval_valid_i,
  input  logic [1:0]       inval_way_i,
  input  logic [SET_W-1:0] inval_set_i,
  output logic             inval_ready_o,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             flush_done_o,
  output logic             lookup_stall_o,
  output logic             update_o,
  output logic             invalidate_one_way_o,
  output logic             invalidate_all_ways_o,
  output logic [1:0]       update_way_o,
  output logic [TAG_W-1:0] update_tag_o,
  output logic [SET_W-1:0] update_set_o,
  output l1_state_e        dbg_state_o
);

  localparam int               ENTRY_W  = L1_WAY_W + TAG_W + SET_W;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  l1_state_e        state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;

  logic             upd_d, inv_one_d, inv_all_d, done_d;
  logic [1:0]       way_d;
  logic [TAG_W-1:0] tag_d;
  logic [SET_W-1:0] set_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [1:0]         head_way;
  logic [TAG_W-1:0]   head_tag;
  logic [SET_W-1:0]   head_set;

  // Handshakes: a fill transfers on a cycle where fill_valid_i && fill_ready_o, an invalidate
  // on a cycle where inval_valid_i && inval_ready_o; valid may not depend on ready.
  l1_fill_fifo #(.W(ENTRY_W)) u_fill_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fill_valid_i),
    .push_data ({fill_way_i, fill_tag_i, fill_set_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_way, head_tag, head_set} = fifo_head;
  assign fill_ready_o   = !fifo_full;
  assign flush_busy_o   = (state_q != STATE_IDLE);
  assign lookup_stall_o = flush_busy_o;
  assign dbg_state_o    = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fifo_pop      = 1'b0;
    inval_ready_o = 1'b0;
    upd_d         = 1'b0;
    inv_one_d     = 1'b0;
    inv_all_d     = 1'b0;
    done_d        = 1'b0;
    way_d         = '0;
    tag_d         = '0;
    set_d         = '0;
    case (state_q)
      STATE_IDLE: begin
        inval_ready_o = !flush_req_i;
        if (flush_req_i) begin
          state_d = STATE_FLUSH;
          cnt_d   = '0;
        end else if (inval_valid_i) begin
          // Invalidate wins over a queued fill so a same-line fill lands afterwards.
          inv_one_d = 1'b1;
          way_d     = inval_way_i;
          set_d     = inval_set_i;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          upd_d    = 1'b1;
          way_d    = head_way;
          tag_d    = head_tag;
          set_d    = head_set;
        end
      end
      STATE_FLUSH: begin
        inv_all_d = 1'b1;
        set_d     = cnt_q;
        cnt_d     = cnt_q + SET_W'(1);
        if (cnt_q == LAST_SET) state_d = STATE_DONE;
      end
      STATE_DONE: begin
        done_d  = 1'b1;
        state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q               <= STATE_IDLE;
      cnt_q                 <= '0;
      update_o              <= 1'b0;
      invalidate_one_way_o  <= 1'b0;
      invalidate_all_ways_o <= 1'b0;
      flush_done_o          <= 1'b0;
      update_way_o          <= '0;
      update_tag_o          <= '0;
      update_set_o          <= '0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      update_o              <= upd_d;
      invalidate_one_way_o  <= inv_one_d;
      invalidate_all_ways_o <= inv_all_d;
      flush_done_o          <= done_d;
      update_way_o          <= way_d;
      update_tag_o          <= tag_d;
      update_set_o          <= set_d;
    end
  end

endmodule

// File: tb/tb_l1_tag_update_ctrl.sv
// Bench for l1_tag_update_ctrl: table-driven idle-state vectors plus hand-written
// flush, back-to-back fill and reset-mid-flush sequences, checked through a timed scoreboard.
module tb_l1_tag_update_ctrl;
  import l1_tag_update_ctrl_pkg::*;

  localparam int NUM_SETS = L1_NUM_SETS;
  localparam int SET_W    = L1_SET_INDEX_WIDTH;
  localparam int TAG_W    = L1_TAG_WIDTH;
  localparam int REC_W    = 16 + 2 + 2 + TAG_W + SET_W;
  localparam logic [1:0] K_UPD    = 2'd1;
  localparam logic [1:0] K_INV1   = 2'd2;
  localparam logic [1:0] K_INVALL = 2'd3;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             reset;
  logic             fill_valid_i;
  logic [1:0]       fill_way_i;
  logic [TAG_W-1:0] fill_tag_i;
  logic [SET_W-1:0] fill_set_i;
  logic             fill_ready_o;
  logic             inval_valid_i;
  logic [1:0]       inval_way_i;
  logic [SET_W-1:0] inval_set_i;
  logic             inval_ready_o;
  logic             flush_req_i;
  logic             flush_busy_o;
  logic             flush_done_o;
  logic             lookup_stall_o;
  logic             update_o;
  logic             invalidate_one_way_o;
  logic             invalidate_all_ways_o;
  logic [1:0]       update_way_o;
  logic [TAG_W-1:0] update_tag_o;
  logic [SET_W-1:0] update_set_o;
  l1_state_e        dbg_state;

  l1_tag_update_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .fill_valid_i          (fill_valid_i),
    .fill_way_i            (fill_way_i),
    .fill_tag_i            (fill_tag_i),
    .fill_set_i            (fill_set_i),
    .fill_ready_o          (fill_ready_o),
    .inval_valid_i         (inval_valid_i),
    .inval_way_i           (inval_way_i),
    .inval_set_i           (inval_set_i),
    .inval_ready_o         (inval_ready_o),
    .flush_req_i           (flush_req_i),
    .flush_busy_o          (flush_busy_o),
    .flush_done_o          (flush_done_o),
    .lookup_stall_o        (lookup_stall_o),
    .update_o              (update_o),
    .invalidate_one_way_o  (invalidate_one_way_o),
    .invalidate_all_ways_o (invalidate_all_ways_o),
    .update_way_o          (update_way_o),
    .update_tag_o          (update_tag_o),
    .update_set_o          (update_set_o),
    .dbg_state_o           (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [REC_W-1:0] exp_q[$];
  int exp_done_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Record fields that the tag array ignores for a command kind are zeroed on both sides.
  function automatic logic [REC_W-1:0] mk_rec(input int c, input logic [1:0] kind,
                                              input logic [1:0] way, input logic [TAG_W-1:0] tag,
                                              input logic [SET_W-1:0] set);
    logic [15:0]      c16;
    logic [1:0]       w;
    logic [TAG_W-1:0] t;
    c16 = c[15:0];
    w   = (kind == K_INVALL) ? 2'd0 : way;
    t   = (kind == K_UPD) ? tag : '0;
    return {c16, kind, w, t, set};
  endfunction

  always @(negedge clk) begin
    int               n;
    logic [1:0]       kind;
    logic [REC_W-1:0] act;
    logic [REC_W-1:0] e;
    if (!reset) begin
      while (exp_q.size() > 0 && int'(exp_q[0][REC_W-1 -: 16]) < cyc) begin
        e = exp_q.pop_front();
        check("missed_cmd", 64'd0, 64'(e));
      end
      n = int'(update_o) + int'(invalidate_one_way_o) + int'(invalidate_all_ways_o);
      if (n > 0) begin
        check("one_hot_cmd", 64'(n), 64'd1);
        kind = update_o ? K_UPD : (invalidate_one_way_o ? K_INV1 : K_INVALL);
        act  = mk_rec(cyc, kind, update_way_o, update_tag_o, update_set_o);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 64'(act), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tag_cmd", 64'(act), 64'(e));
        end
      end
      if (flush_done_o || cyc == exp_done_cyc)
        check("flush_done", 64'(flush_done_o), 64'(cyc == exp_done_cyc));
      if (flush_busy_o || lookup_stall_o)
        check("stall_eq_busy", 64'(lookup_stall_o), 64'(flush_busy_o));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fill_valid_i  = 1'b0;
    fill_way_i    = '0;
    fill_tag_i    = '0;
    fill_set_i    = '0;
    inval_valid_i = 1'b0;
    inval_way_i   = '0;
    inval_set_i   = '0;
    flush_req_i   = 1'b0;
  endtask

  task automatic drive_fill(input logic [1:0] w, input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s);
    fill_valid_i = 1'b1;
    fill_way_i   = w;
    fill_tag_i   = t;
    fill_set_i   = s;
  endtask

  task automatic push_flush_exp(input int k, input int nsets);
    for (int i = 0; i < nsets; i++)
      exp_q.push_back(mk_rec(k + 2 + i, K_INVALL, 2'd0, '0, SET_W'(i)));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_update"},   64'(update_o),              64'd0);
    check({tag, "_inv1"},     64'(invalidate_one_way_o),  64'd0);
    check({tag, "_invall"},   64'(invalidate_all_ways_o), 64'd0);
    check({tag, "_done"},     64'(flush_done_o),          64'd0);
    check({tag, "_busy"},     64'(flush_busy_o),          64'd0);
    check({tag, "_stall"},    64'(lookup_stall_o),        64'd0);
    check({tag, "_fill_rdy"}, 64'(fill_ready_o),          64'd1);
    check({tag, "_inv_rdy"},  64'(inval_ready_o),         64'd1);
    check({tag, "_wts"},      64'({update_way_o, update_tag_o, update_set_o}), 64'd0);
  endtask

  task automatic run_until(input int target);
    for (int g = 0; g < 200 && cyc < target; g++) tick();
    if (cyc != target) check("run_until_budget", 64'(cyc), 64'(target));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             fv;
    logic [1:0]       fw;
    logic [TAG_W-1:0] ft;
    logic [SET_W-1:0] fset;
    logic             iv;
    logic [1:0]       iw;
    logic [SET_W-1:0] iset;
    logic             exp_fill_ready;
    logic             exp_inval_ready;
    int               fill_lat;
    int               inval_lat;
  } vec_t;

  function automatic vec_t mk_vec(input logic fv, input logic [1:0] fw, input logic [TAG_W-1:0] ft,
                                  input logic [SET_W-1:0] fset, input logic iv, input logic [1:0] iw,
                                  input logic [SET_W-1:0] iset);
    vec_t v;
    v.fv = fv; v.fw = fw; v.ft = ft; v.fset = fset;
    v.iv = iv; v.iw = iw; v.iset = iset;
    v.exp_fill_ready  = 1'b1;
    v.exp_inval_ready = 1'b1;
    v.fill_lat        = 2;
    v.inval_lat       = 1;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    int k;
    int k2;
    reset = 1'b1;
    idle_inputs();

    vecs[0] = mk_vec(1'b1, 2'd2, TAG_W'(20'h01234), SET_W'(5),  1'b0, 2'd0, '0);
    vecs[1] = mk_vec(1'b0, 2'd0, '0,                '0,         1'b1, 2'd1, SET_W'(7));
    vecs[2] = mk_vec(1'b1, 2'd1, TAG_W'(20'hABCDE), SET_W'(7),  1'b1, 2'd1, SET_W'(7));
    vecs[3] = mk_vec(1'b1, 2'd3, TAG_W'(20'hFFFFF), SET_W'(63), 1'b1, 2'd0, SET_W'(0));
    for (int r = 4; r < 8; r++)
      vecs[r] = mk_vec(1'b1, 2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, (1 << TAG_W) - 1)),
                       SET_W'($urandom_range(0, NUM_SETS - 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), SET_W'($urandom_range(0, NUM_SETS - 1)));

    repeat (3) tick();
    @(negedge clk);
    check_reset_values("in_reset");
    tick();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_reset_values("after_reset");

    // Isolated idle-state vectors: each starts with an empty FIFO.
    for (int r = 0; r < 8; r++) begin
      tick();
      fill_valid_i  = vecs[r].fv;
      fill_way_i    = vecs[r].fw;
      fill_tag_i    = vecs[r].ft;
      fill_set_i    = vecs[r].fset;
      inval_valid_i = vecs[r].iv;
      inval_way_i   = vecs[r].iw;
      inval_set_i   = vecs[r].iset;
      k = cyc;
      if (vecs[r].iv) exp_q.push_back(mk_rec(k + vecs[r].inval_lat, K_INV1, vecs[r].iw, '0, vecs[r].iset));
      if (vecs[r].fv) exp_q.push_back(mk_rec(k + vecs[r].fill_lat, K_UPD, vecs[r].fw, vecs[r].ft, vecs[r].fset));
      @(negedge clk);
      check("row_fill_ready",  64'(fill_ready_o),  64'(vecs[r].exp_fill_ready));
      check("row_inval_ready", 64'(inval_ready_o), 64'(vecs[r].exp_inval_ready));
      tick();
      idle_inputs();
      repeat (3) tick();
    end

    // Back-to-back fills: push and pop together at one entry keeps order.
    tick();
    drive_fill(2'd0, TAG_W'(20'h00AAA), SET_W'(10));
    k = cyc;
    exp_q.push_back(mk_rec(k + 2, K_UPD, 2'd0, TAG_W'(20'h00AAA), SET_W'(10)));
    tick();
    drive_fill(2'd3, TAG_W'(20'h00BBB), SET_W'(11));
    exp_q.push_back(mk_rec(k + 3, K_UPD, 2'd3, TAG_W'(20'h00BBB), SET_W'(11)));
    @(negedge clk);
    check("b2b_fill_ready", 64'(fill_ready_o), 64'd1);
    tick();
    idle_inputs();
    repeat (4) tick();

    // Flush with fills arriving while busy; an invalidate in the request cycle is refused.
    tick();
    flush_req_i   = 1'b1;
    inval_valid_i = 1'b1;
    inval_way_i   = 2'd2;
    inval_set_i   = SET_W'(3);
    k = cyc;
    push_flush_exp(k, NUM_SETS);
    exp_done_cyc = k + NUM_SETS + 2;
    @(negedge clk);
    check("flush_req_inval_ready", 64'(inval_ready_o), 64'd0);
    tick();
    idle_inputs();
    drive_fill(2'd1, TAG_W'(20'h11111), SET_W'(1));
    exp_q.push_back(mk_rec(k + NUM_SETS + 3, K_UPD, 2'd1, TAG_W'(20'h11111), SET_W'(1)));
    @(negedge clk);
    check("flush_busy", 64'(flush_busy_o), 64'd1);
    check("flush_fill_a_ready", 64'(fill_ready_o), 64'd1);
    tick();
    drive_fill(2'd2, TAG_W'(20'h22222), SET_W'(2));
    exp_q.push_back(mk_rec(k + NUM_SETS + 4, K_UPD, 2'd2, TAG_W'(20'h22222), SET_W'(2)));
    @(negedge clk);
    check("flush_fill_b_ready", 64'(fill_ready_o), 64'd1);
    tick();
    drive_fill(2'd3, TAG_W'(20'h33333), SET_W'(3));
    @(negedge clk);
    check("fifo_full_ready", 64'(fill_ready_o), 64'd0);
    tick();
    idle_inputs();
    tick();
    inval_valid_i = 1'b1;
    inval_way_i   = 2'd3;
    inval_set_i   = SET_W'(9);
    @(negedge clk);
    check("flush_inval_ready", 64'(inval_ready_o), 64'd0);
    tick();
    idle_inputs();
    run_until(k + 10);
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    run_until(k + NUM_SETS + 1);
    flush_req_i = 1'b1;
    @(negedge clk);
    check("done_state_busy", 64'(flush_busy_o), 64'd1);
    tick();
    flush_req_i = 1'b0;
    @(negedge clk);
    check("after_done_busy", 64'(flush_busy_o), 64'd0);
    repeat (5) tick();
    exp_done_cyc = -1;

    // Reset while the set counter is 20: sets 0..18 are seen, the in-flight set 19 is cleared.
    tick();
    flush_req_i = 1'b1;
    k = cyc;
    push_flush_exp(k, 19);
    tick();
    flush_req_i = 1'b0;
    drive_fill(2'd1, TAG_W'(20'h0DEAD), SET_W'(4));
    tick();
    idle_inputs();
    run_until(k + 21);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_flush_reset");
    tick();
    reset = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check_reset_values("post_flush_reset");

    tick();
    flush_req_i = 1'b1;
    k2 = cyc;
    push_flush_exp(k2, NUM_SETS);
    exp_done_cyc = k2 + NUM_SETS + 2;
    tick();
    flush_req_i = 1'b0;
    run_until(k2 + NUM_SETS + 4);
    exp_done_cyc = -1;
    repeat (3) tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
